// File: rtl/phase_seq_ctrl.sv
// Eight-phase run sequencer: N full phase cycles with hold, abort and done.
// Optional PHASE_SEQ_SKIP_EN adds skip_mask to skip phases 1..7.
module phase_seq_ctrl #(
  parameter int CYCLES_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CYCLES_W-1:0] cmd_cycles,
  input  logic                hold,
  input  logic                abort,
`ifdef PHASE_SEQ_SKIP_EN
  input  logic [7:0]          skip_mask,
`endif
  output logic [2:0]          phase,
  output logic                phase_odd,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [CYCLES_W-1:0] cycles_left
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [2:0]          phase_n;
  logic [CYCLES_W-1:0] left_n;
  logic                aborted_q, aborted_n;
  logic [2:0]          adv;
  logic                wrap;

`ifdef PHASE_SEQ_SKIP_EN
  logic [7:0] eff_mask;
  logic       found;
  logic [2:0] cand;

  // First unmasked index above the current phase; phase 0 is always eligible.
  always_comb begin
    eff_mask = {skip_mask[7:1], 1'b0};
    found    = 1'b0;
    adv      = 3'd0;
    cand     = 3'd0;
    for (int i = 1; i < 8; i++) begin
      cand = phase + 3'(i);
      if (!found && !eff_mask[cand]) begin
        adv   = cand;
        found = 1'b1;
      end
    end
    wrap = (adv <= phase);
  end
`else
  always_comb begin
    adv  = phase + 3'd1;
    wrap = (phase == 3'd7);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= 3'd0;
      cycles_left <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      cycles_left <= left_n;
      aborted_q   <= aborted_n;
    end
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    left_n    = cycles_left;
    aborted_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          phase_n = 3'd0;
          if (cmd_cycles == '0) begin
            state_n = DONE;
            left_n  = '0;
          end else begin
            state_n = RUN;
            left_n  = cmd_cycles;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_n   = IDLE;
          phase_n   = 3'd0;
          left_n    = '0;
          aborted_n = 1'b1;
        end else if (!hold) begin
          phase_n = adv;
          if (wrap) begin
            if (cycles_left == CYCLES_W'(1)) begin
              state_n = DONE;
              phase_n = 3'd0;
              left_n  = '0;
            end else begin
              left_n = cycles_left - CYCLES_W'(1);
            end
          end
        end
      end
      DONE: state_n = IDLE;
      default: begin
        state_n = IDLE;
        phase_n = 3'd0;
        left_n  = '0;
      end
    endcase
  end

  assign cmd_ready = reset || (state == IDLE);
  assign busy      = !reset && (state == RUN);
  assign done      = !reset && (state == DONE);
  assign aborted   = !reset && aborted_q;
  assign phase_odd = busy && phase[0];

endmodule
